wf_fetch_arbiter: RTL and testbench



---
 rtl/wf_fetch_arbiter.sv | 154 +++++++++++++++
 tb/tb_wf_fetch_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wf_fetch_arbiter.sv
// Round-robin instruction-fetch arbiter over 40 wavefront slots with a global in-flight cap.
// Define FETCH_ARB_PERF_EN to add grant/stall/cap-stall performance counters.
module wf_fetch_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [39:0]      valid_wf,
  input  logic [39:0]      wf_halt,
  input  logic [39:0]      ibuf_full,
  input  logic             fetch_ack,
  input  logic             fetch_done,
  input  logic [5:0]       fetch_done_wfid,
  output logic             fetch_req,
  output logic [5:0]       fetch_wfid,
  output logic [39:0]      outstanding,
  output logic [CNT_W-1:0] inflight_cnt
`ifdef FETCH_ARB_PERF_EN
  ,
  output logic [31:0]      grant_count,
  output logic [31:0]      stall_count,
  output logic [31:0]      cap_stall_count
`endif
);

  localparam int NWF = 40;

  // Handshake: fetch_req/fetch_wfid come straight from flops; once raised they
  // hold until the cycle fetch_ack is seen high, and a transfer is req & ack.
  typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [5:0]       last_grant;
  logic [5:0]       wfid_d;
  logic [5:0]       last_grant_d;
  logic [39:0]      outstanding_d;
  logic [CNT_W-1:0] cnt_d;

  logic [39:0] eligible;
  logic        cap_ok;
  logic        cap_ok_post;
  logic        grant;
  logic [39:0] grant_oh;
  logic [39:0] done_oh;
  logic        done_hit;
  logic [6:0]  sel_idle;
  logic [6:0]  sel_b2b;

  // Returns {found, index}: first set bit of mask after ptr, wrapping 39 -> 0.
  function automatic logic [6:0] rr_pick(input logic [39:0] mask, input logic [5:0] ptr);
    logic       found;
    logic [5:0] idx;
    logic [6:0] p;
    found = 1'b0;
    idx   = 6'd0;
    for (int k = 1; k <= NWF; k++) begin
      p = {1'b0, ptr} + 7'(k);
      if (p >= 7'(NWF)) p = p - 7'(NWF);
      if (!found && mask[p[5:0]]) begin
        found = 1'b1;
        idx   = p[5:0];
      end
    end
    return {found, idx};
  endfunction

  assign eligible = valid_wf & ~wf_halt & ~ibuf_full & ~outstanding;
  assign cap_ok   = (inflight_cnt < CNT_W'(MAX_OUTSTANDING));
  assign grant    = (state_q == REQ) && fetch_ack;
  assign grant_oh = 40'd1 << fetch_wfid;
  // Shifting past bit 39 yields zero, so out-of-range done ids never hit.
  assign done_oh  = 40'd1 << fetch_done_wfid;
  assign done_hit = fetch_done && |(outstanding & done_oh);

  assign outstanding_d = (outstanding | (grant ? grant_oh : 40'd0))
                       & ~(done_hit ? done_oh : 40'd0);

  always_comb begin
    cnt_d = inflight_cnt;
    if (grant && !done_hit)      cnt_d = inflight_cnt + CNT_W'(1);
    else if (!grant && done_hit) cnt_d = inflight_cnt - CNT_W'(1);
  end

  assign cap_ok_post = (cnt_d < CNT_W'(MAX_OUTSTANDING));
  assign sel_idle    = rr_pick(eligible, last_grant);
  // Back-to-back pick: the slot just granted is not yet in outstanding, so mask it here.
  assign sel_b2b     = rr_pick(eligible & ~grant_oh, fetch_wfid);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_wfid   <= 6'd0;
      last_grant   <= 6'd39;
      outstanding  <= 40'd0;
      inflight_cnt <= '0;
    end else begin
      state_q      <= state_d;
      fetch_wfid   <= wfid_d;
      last_grant   <= last_grant_d;
      outstanding  <= outstanding_d;
      inflight_cnt <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cap_ok && sel_idle[6]) state_d = REQ;
      REQ: begin
        if (fetch_ack) begin
          if (cap_ok_post && sel_b2b[6]) state_d = REQ;
          else                           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath decisions.
  always_comb begin
    wfid_d       = fetch_wfid;
    last_grant_d = last_grant;
    case (state_q)
      IDLE: if (cap_ok && sel_idle[6]) wfid_d = sel_idle[5:0];
      REQ: begin
        if (fetch_ack) begin
          last_grant_d = fetch_wfid;
          if (cap_ok_post && sel_b2b[6]) wfid_d = sel_b2b[5:0];
        end
      end
      default: wfid_d = fetch_wfid;
    endcase
  end

  assign fetch_req = (state_q == REQ);

`ifdef FETCH_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_count     <= 32'd0;
      stall_count     <= 32'd0;
      cap_stall_count <= 32'd0;
    end else begin
      if (fetch_req && fetch_ack)  grant_count     <= grant_count + 32'd1;
      if (fetch_req && !fetch_ack) stall_count     <= stall_count + 32'd1;
      if (|eligible && !cap_ok)    cap_stall_count <= cap_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wf_fetch_arbiter.sv
// Table-driven bench for wf_fetch_arbiter with hand-written hold/reset sequences.
// Perf counter checks are compiled in when FETCH_ARB_PERF_EN is defined.
module tb_wf_fetch_arbiter;

  localparam logic [39:0] ALL = 40'hFF_FFFF_FFFF;
  localparam logic [39:0] B39 = 40'h80_0000_0000;
  localparam logic [39:0] B2  = 40'h00_0000_0004;

  logic        clk;
  logic        rst;
  logic [39:0] valid_wf, wf_halt, ibuf_full;
  logic        fetch_ack, fetch_done;
  logic [5:0]  fetch_done_wfid;
  logic        fetch_req;
  logic [5:0]  fetch_wfid;
  logic [39:0] outstanding;
  logic [2:0]  inflight_cnt;
`ifdef FETCH_ARB_PERF_EN
  logic [31:0] grant_count, stall_count, cap_stall_count;
`endif

  int checks = 0;
  int errors = 0;

  wf_fetch_arbiter #(.MAX_OUTSTANDING(4), .CNT_W(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_wf        (valid_wf),
    .wf_halt         (wf_halt),
    .ibuf_full       (ibuf_full),
    .fetch_ack       (fetch_ack),
    .fetch_done      (fetch_done),
    .fetch_done_wfid (fetch_done_wfid),
    .fetch_req       (fetch_req),
    .fetch_wfid      (fetch_wfid),
    .outstanding     (outstanding),
    .inflight_cnt    (inflight_cnt)
`ifdef FETCH_ARB_PERF_EN
    ,
    .grant_count     (grant_count),
    .stall_count     (stall_count),
    .cap_stall_count (cap_stall_count)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic [39:0] valid;
    logic [39:0] halt;
    logic [39:0] full;
    logic        ack;
    logic        done;
    logic [5:0]  done_wfid;
    logic        exp_req;
    logic [5:0]  exp_wfid;
    logic [39:0] exp_out;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [39:0] v, input logic [39:0] h,
                     input logic [39:0] f, input logic a, input logic d,
                     input logic [5:0] dw, input logic er, input logic [5:0] ew,
                     input logic [39:0] eo, input logic [2:0] ec);
    vec_t t;
    t.rst = r; t.valid = v; t.halt = h; t.full = f; t.ack = a; t.done = d;
    t.done_wfid = dw; t.exp_req = er; t.exp_wfid = ew; t.exp_out = eo; t.exp_cnt = ec;
    vecs.push_back(t);
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic er, input logic [5:0] ew,
                         input logic [39:0] eo, input logic [2:0] ec);
    chk({tag, "_req"},  64'(fetch_req),    64'(er));
    chk({tag, "_wfid"}, 64'(fetch_wfid),   64'(ew));
    chk({tag, "_out"},  64'(outstanding),  64'(eo));
    chk({tag, "_cnt"},  64'(inflight_cnt), 64'(ec));
  endtask

  task automatic drive_idle();
    rst = 1'b0; valid_wf = '0; wf_halt = '0; ibuf_full = '0;
    fetch_ack = 1'b0; fetch_done = 1'b0; fetch_done_wfid = '0;
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;

    // rst valid halt full ack done dwfid | req wfid out cnt
    // Fill to the cap, free a slot, ignore bogus dones.
    add(1, ALL, 0, 0, 1, 0,  0,  0,  0, 40'h0,  0);
    add(0, ALL, 0, 0, 1, 0,  0,  1,  0, 40'h0,  0);
    add(0, ALL, 0, 0, 1, 0,  0,  1,  1, 40'h1,  1);
    add(0, ALL, 0, 0, 1, 0,  0,  1,  2, 40'h3,  2);
    add(0, ALL, 0, 0, 1, 0,  0,  1,  3, 40'h7,  3);
    add(0, ALL, 0, 0, 1, 0,  0,  0,  3, 40'hF,  4);
    add(0, ALL, 0, 0, 1, 0,  0,  0,  3, 40'hF,  4);
    add(0, ALL, 0, 0, 1, 1,  1,  0,  3, 40'hD,  3);
    add(0, ALL, 0, 0, 1, 0,  0,  1,  4, 40'hD,  3);
    add(0, ALL, 0, 0, 1, 0,  0,  0,  4, 40'h1D, 4);
    add(0, ALL, 0, 0, 1, 1, 45,  0,  4, 40'h1D, 4);
    add(0, ALL, 0, 0, 1, 1,  9,  0,  4, 40'h1D, 4);
    // Halt and buffer-full exclude slots 0 and 1.
    add(1, ALL, 1, 2, 0, 0,  0,  0,  0, 40'h0,  0);
    add(0, ALL, 1, 2, 0, 0,  0,  1,  2, 40'h0,  0);
    add(0, ALL, 1, 2, 0, 0,  0,  1,  2, 40'h0,  0);
    add(0, ALL, 1, 2, 1, 0,  0,  1,  3, 40'h4,  1);
    // Same-cycle ack (5) and done (2), then a spurious done (9).
    add(1, 40'h27, 0, 0, 1, 0, 0, 0, 0, 40'h0,  0);
    add(0, 40'h27, 0, 0, 1, 0, 0, 1, 0, 40'h0,  0);
    add(0, 40'h27, 0, 0, 1, 0, 0, 1, 1, 40'h1,  1);
    add(0, 40'h27, 0, 0, 1, 0, 0, 1, 2, 40'h3,  2);
    add(0, 40'h27, 0, 0, 1, 0, 0, 1, 5, 40'h7,  3);
    add(0, 40'h27, 0, 0, 1, 1, 2, 0, 5, 40'h23, 3);
    add(0, 40'h27, 0, 0, 0, 1, 9, 1, 2, 40'h23, 3);
    add(0, 40'h27, 0, 0, 0, 0, 0, 1, 2, 40'h23, 3);
    // Wrap between slots 39 and 2.
    add(1, B39,      0, 0, 1, 0,  0, 0,  0, 40'h0, 0);
    add(0, B39,      0, 0, 1, 0,  0, 1, 39, 40'h0, 0);
    add(0, B39,      0, 0, 1, 0,  0, 0, 39, B39,   1);
    add(0, B39 | B2, 0, 0, 1, 1, 39, 1,  2, 40'h0, 0);
    add(0, B39 | B2, 0, 0, 1, 0,  0, 1, 39, B2,    1);
    add(0, B39 | B2, 0, 0, 1, 1,  2, 0, 39, B39,   1);
    add(0, B39 | B2, 0, 0, 1, 1, 39, 1,  2, 40'h0, 0);
    add(0, B39 | B2, 0, 0, 1, 0,  0, 1, 39, B2,    1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; valid_wf = vecs[i].valid; wf_halt = vecs[i].halt;
      ibuf_full = vecs[i].full; fetch_ack = vecs[i].ack; fetch_done = vecs[i].done;
      fetch_done_wfid = vecs[i].done_wfid;
      step();
      chk_all($sformatf("row%0d", i), vecs[i].exp_req, vecs[i].exp_wfid,
              vecs[i].exp_out, vecs[i].exp_cnt);
    end

    // Request for slot 7 held without ack while its valid drops.
    drive_idle();
    rst = 1'b1;
    step();
    rst = 1'b0; valid_wf = 40'h80;
    step();
    chk_all("hold_start", 1'b1, 6'd7, 40'h0, 3'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) valid_wf = '0;
      step();
      chk_all($sformatf("hold%0d", i), 1'b1, 6'd7, 40'h0, 3'd0);
    end
    fetch_ack = 1'b1;
    step();
    chk_all("hold_ack", 1'b0, 6'd7, 40'h80, 3'd1);

    // Reset in the middle of a pending request; late done is ignored.
    fetch_ack = 1'b0; valid_wf = ALL;
    step();
    chk_all("midrst_req", 1'b1, 6'd8, 40'h80, 3'd1);
    rst = 1'b1;
    step();
    chk_all("midrst_rst", 1'b0, 6'd0, 40'h0, 3'd0);
    rst = 1'b0; valid_wf = '0; fetch_done = 1'b1; fetch_done_wfid = 6'd7;
    step();
    chk_all("midrst_done", 1'b0, 6'd0, 40'h0, 3'd0);

`ifdef FETCH_ARB_PERF_EN
    drive_idle();
    rst = 1'b1;
    step();
    rst = 1'b0; valid_wf = 40'h8;
    step();
    for (int i = 0; i < 3; i++) step();
    chk("perf_stall3", 64'(stall_count), 64'd3);
    chk("perf_grant0", 64'(grant_count), 64'd0);
    fetch_ack = 1'b1;
    step();
    chk("perf_grant1", 64'(grant_count), 64'd1);
    chk("perf_stall_hold", 64'(stall_count), 64'd3);
    rst = 1'b1;
    step();
    chk("perf_rst_grant", 64'(grant_count), 64'd0);
    chk("perf_rst_stall", 64'(stall_count), 64'd0);
    chk("perf_rst_cap", 64'(cap_stall_count), 64'd0);
    chk_all("perf_rst", 1'b0, 6'd0, 40'h0, 3'd0);
    rst = 1'b0;
`endif

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
